// File: rtl/pixel_scan_ctrl.sv
// Raster scan sequencer: walks x/y over one frame, issues each pixel to the
// iteration engine, takes its result and strobes a frame-buffer write.
module pixel_scan_ctrl #(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 9,
  parameter int ADDR_BITS  = 19,
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [NUM_X_BITS-1:0] pixel_x,
  output logic [NUM_Y_BITS-1:0] pixel_y,
  input  logic                  res_valid,
  output logic                  res_ready,
  output logic                  wr_en,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADVANCE,
    DONE
  } state_t;

  localparam logic [NUM_X_BITS-1:0] X_LAST = NUM_X_BITS'(H_PIXELS - 1);
  localparam logic [NUM_Y_BITS-1:0] Y_LAST = NUM_Y_BITS'(V_PIXELS - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [NUM_X_BITS-1:0]   x_nx;
  logic [NUM_Y_BITS-1:0]   y_nx;
  logic [ADDR_BITS-1:0]    addr_nx;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      pixel_x <= '0;
      pixel_y <= '0;
      wr_addr <= '0;
    end else begin
      state   <= state_nx;
      pixel_x <= x_nx;
      pixel_y <= y_nx;
      wr_addr <= addr_nx;
    end
  end

  // Address tracks the scan linearly, so no y*H product is ever formed.
  always_comb begin
    state_nx = state;
    x_nx     = pixel_x;
    y_nx     = pixel_y;
    addr_nx  = wr_addr;
    if (abort) begin
      state_nx = IDLE;
      x_nx     = '0;
      y_nx     = '0;
      addr_nx  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = ISSUE;
            x_nx     = '0;
            y_nx     = '0;
            addr_nx  = '0;
          end
        end
        ISSUE: begin
          if (req_ready) state_nx = WAIT;
        end
        WAIT: begin
          if (res_valid) state_nx = ADVANCE;
        end
        ADVANCE: begin
          if (pixel_x != X_LAST) begin
            state_nx = ISSUE;
            x_nx     = pixel_x + NUM_X_BITS'(1);
            addr_nx  = wr_addr + ADDR_BITS'(1);
          end else if (pixel_y != Y_LAST) begin
            state_nx = ISSUE;
            x_nx     = '0;
            y_nx     = pixel_y + NUM_Y_BITS'(1);
            addr_nx  = wr_addr + ADDR_BITS'(1);
          end else begin
            state_nx = DONE;
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  assign req_valid  = (state == ISSUE);
  assign res_ready  = (state == WAIT);
  assign wr_en      = (state == ADVANCE);
  assign frame_done = (state == DONE);
  assign busy       = (state == ISSUE) || (state == WAIT) ||
                      (state == ADVANCE);

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl on a 4x3 frame: handshake stalls,
// stray results, abort, ignored starts and mid-frame reset.
module tb_pixel_scan_ctrl;

  localparam int XB = 10;
  localparam int YB = 9;
  localparam int AB = 19;
  localparam int H  = 4;
  localparam int V  = 3;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic          abort;
  logic          req_valid;
  logic          req_ready;
  logic [XB-1:0] pixel_x;
  logic [YB-1:0] pixel_y;
  logic          res_valid;
  logic          res_ready;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic          busy;
  logic          frame_done;

  pixel_scan_ctrl #(
    .NUM_X_BITS(XB),
    .NUM_Y_BITS(YB),
    .ADDR_BITS (AB),
    .H_PIXELS  (H),
    .V_PIXELS  (V)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int wa[$];
  int wx[$];
  int wy[$];
  int wc[$];
  int dq[$];

  int mode       = 3;
  int stall_left = 0;
  int rv_cnt     = 0;
  int wcnt       = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor
  always @(negedge clk) begin
    if (n_rst) begin
      if (wr_en) begin
        wa.push_back(int'(wr_addr));
        wx.push_back(int'(pixel_x));
        wy.push_back(int'(pixel_y));
        wc.push_back(cyc);
      end
      if (frame_done) begin
        dq.push_back(cyc);
        chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Engine model: 0 always ready, 1 stall on (2,1), 2 slow result
  always @(negedge clk) begin
    case (mode)
      0: begin
        req_ready = 1'b1;
        res_valid = 1'b1;
      end
      1: begin
        res_valid = 1'b1;
        req_ready = 1'b1;
        if (req_valid && pixel_x == 2 && pixel_y == 1) begin
          rv_cnt++;
          if (stall_left > 0) begin
            req_ready = 1'b0;
            stall_left--;
          end
        end
      end
      2: begin
        req_ready = 1'b1;
        if (res_ready) wcnt++;
        else wcnt = 0;
        res_valid = req_valid || (res_ready && wcnt >= 3);
      end
      default: begin
        req_ready = 1'b0;
        res_valid = 1'b0;
      end
    endcase
  end

  task automatic clear_log();
    wa.delete();
    wx.delete();
    wy.delete();
    wc.delete();
    dq.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_nwr"}, wa.size(), H * V);
    for (int i = 0; i < wa.size(); i++) begin
      chk({tag, "_addr"}, wa[i], i);
      chk({tag, "_x"}, wx[i], i % H);
      chk({tag, "_y"}, wy[i], i / H);
    end
    chk({tag, "_ndone"}, dq.size(), 1);
    if (dq.size() > 0 && wc.size() > 0)
      chk({tag, "_done_lat"}, dq[0] - wc[wc.size()-1], 1);
  endtask

  initial begin
    n_rst     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    req_ready = 1'b0;
    res_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", int'(req_valid), 0);
    chk("rst_res_ready", int'(res_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_x", int'(pixel_x), 0);
    chk("rst_y", int'(pixel_y), 0);
    chk("rst_addr", int'(wr_addr), 0);
    n_rst = 1'b1;

    // Full-rate frame
    mode = 0;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    clear_log();
    pulse_start();
    wait_done(100);
    repeat (2) @(negedge clk);
    check_frame("t1");
    for (int i = 1; i < wc.size(); i++)
      chk("t1_spacing", wc[i] - wc[i-1], 3);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_hold_x", int'(pixel_x), H - 1);
    chk("t1_hold_y", int'(pixel_y), V - 1);
    chk("t1_hold_addr", int'(wr_addr), H * V - 1);

    // Request stall on pixel (2,1)
    mode       = 1;
    stall_left = 5;
    rv_cnt     = 0;
    clear_log();
    pulse_start();
    wait_done(150);
    repeat (2) @(negedge clk);
    check_frame("t2");
    chk("t2_rv_cycles", rv_cnt, 6);
    if (wc.size() == H * V)
      chk("t2_span", wc[H*V-1] - wc[0], 3 * (H * V - 1) + 5);

    // Stray result during ISSUE, real one later in WAIT
    mode = 2;
    wcnt = 0;
    clear_log();
    pulse_start();
    wait_done(200);
    repeat (2) @(negedge clk);
    check_frame("t3");
    if (wc.size() == H * V)
      chk("t3_span", wc[H*V-1] - wc[0], 5 * (H * V - 1));

    // Abort in WAIT at pixel (1,2)
    mode = 0;
    clear_log();
    pulse_start();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (res_ready && pixel_x == 1 && pixel_y == 2) hit = 1'b1;
      end
      chk("t4_reach_wait", int'(hit), 1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_req_valid", int'(req_valid), 0);
    chk("t4_x", int'(pixel_x), 0);
    chk("t4_y", int'(pixel_y), 0);
    chk("t4_addr", int'(wr_addr), 0);
    repeat (10) @(negedge clk);
    chk("t4_nwr", wa.size(), 9);
    chk("t4_ndone", dq.size(), 0);
    clear_log();
    pulse_start();
    wait_done(100);
    repeat (2) @(negedge clk);
    check_frame("t4r");

    // Start while busy and while in DONE
    clear_log();
    pulse_start();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (wa.size() >= 5) hit = 1'b1;
      end
      chk("t5_mid", int'(hit), 1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_frame("t5");
    chk("t5_busy_after", int'(busy), 0);

    // Async reset mid-frame with a request pending
    clear_log();
    pulse_start();
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (wa.size() >= 4 && req_valid) hit = 1'b1;
      end
      chk("t6_mid", int'(hit), 1);
    end
    n_rst = 1'b0;
    #1;
    chk("t6_req_valid", int'(req_valid), 0);
    chk("t6_res_ready", int'(res_ready), 0);
    chk("t6_wr_en", int'(wr_en), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(frame_done), 0);
    chk("t6_x", int'(pixel_x), 0);
    chk("t6_y", int'(pixel_y), 0);
    chk("t6_addr", int'(wr_addr), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle_busy", int'(busy), 0);
    chk("t6_idle_rv", int'(req_valid), 0);
    clear_log();
    pulse_start();
    wait_done(100);
    repeat (2) @(negedge clk);
    check_frame("t6r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
